// File: rtl/switch_debounce8_pkg.sv
// ============================================================================
// switch_debounce8_pkg : shared constants for the 8-channel switch debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

package switch_debounce8_pkg;

    localparam int   DB_CYCLES_DEFAULT = 1_000_000;
    localparam int   DB_CYCLES_SIM     = 4;
    localparam logic SW_IDLE           = 1'b1;
    localparam int   N_SW              = 8;

endpackage

`default_nettype wire

// File: rtl/switch_debounce8_ch.sv
// ============================================================================
// debounce_ch : one channel - 2-flop sync, qualification counter, level, strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_ch
    import switch_debounce8_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic db_n,
    output logic db_n_next,
    output logic fall_p,
    output logic rise_p
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          fall_q, fall_d;
    logic          rise_q, rise_d;

    always_comb begin
        s1_d   = raw_n;
        s2_d   = s1_q;
        cnt_d  = '0;
        db_d   = db_q;
        fall_d = 1'b0;
        rise_d = 1'b0;
        // Any sample matching the accepted level drops the count back to zero.
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d   = s2_q;
                fall_d = ~s2_q;
                rise_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= SW_IDLE;
            s2_q   <= SW_IDLE;
            cnt_q  <= '0;
            db_q   <= SW_IDLE;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            fall_q <= fall_d;
            rise_q <= rise_d;
        end
    end

    assign db_n      = db_q;
    assign db_n_next = db_d;
    assign fall_p    = fall_q;
    assign rise_p    = rise_q;

endmodule

`default_nettype wire

// File: rtl/switch_debounce8.sv
// ============================================================================
// switch_debounce8 : N independent debounced active-low channels + activity flag
// Rev 1.0
// ============================================================================
`default_nettype none

module switch_debounce8
    import switch_debounce8_pkg::*;
#(
    parameter int N         = N_SW,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] raw_n,
    output logic [N-1:0] db_n,
    output logic [N-1:0] fall_p,
    output logic [N-1:0] rise_p,
    output logic         any_act
);

    logic [N-1:0] db_n_next;
    logic         any_act_q, any_act_d;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            debounce_ch #(
                .DB_CYCLES (DB_CYCLES)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .raw_n     (raw_n[i]),
                .db_n      (db_n[i]),
                .db_n_next (db_n_next[i]),
                .fall_p    (fall_p[i]),
                .rise_p    (rise_p[i])
            );
        end
    endgenerate

    // Built from the next-state levels so the flag changes on the same edge as db_n.
    always_comb begin
        any_act_d = ~&db_n_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_act_q <= 1'b0;
        end else begin
            any_act_q <= any_act_d;
        end
    end

    assign any_act = any_act_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce8.sv
// ============================================================================
// tb_switch_debounce8 : directed + random bench for switch_debounce8 (DB_CYCLES=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_switch_debounce8;
    import switch_debounce8_pkg::*;

    localparam int N  = N_SW;
    localparam int DB = DB_CYCLES_SIM;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_n = '1;
    logic [N-1:0] db_n;
    logic [N-1:0] fall_p;
    logic [N-1:0] rise_p;
    logic         any_act;

    int checks   = 0;
    int failures = 0;

    // Reference: a level is accepted once the last DB synchronised samples all disagree with it.
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_db = '1, m_fall = '0, m_rise = '0;
    logic         m_any = 1'b0;
    logic [N-1:0] hist[$];

    switch_debounce8 #(
        .N         (N),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_n   (raw_n),
        .db_n    (db_n),
        .fall_p  (fall_p),
        .rise_p  (rise_p),
        .any_act (any_act)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [N-1:0] raw, input logic rst);
        logic [N-1:0] nd;
        int           n;
        @(negedge clk);
        raw_n = raw;
        rst_n = rst;
        @(posedge clk);
        if (!rst) begin
            m_s1 = '1; m_s2 = '1; m_db = '1; m_fall = '0; m_rise = '0; m_any = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            n  = hist.size();
            nd = m_db;
            if (n >= DB) begin
                for (int i = 0; i < N; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = n - DB; j < n; j++)
                        if (hist[j][i] == m_db[i]) all_diff = 1'b0;
                    if (all_diff) nd[i] = ~m_db[i];
                end
            end
            m_fall = m_db & ~nd;
            m_rise = ~m_db & nd;
            m_db   = nd;
            m_any  = ~&nd;
            m_s2   = m_s1;
            m_s1   = raw;
            if (n > 32) void'(hist.pop_front());
        end
        #1;
        chk("model_db", 32'(db_n), 32'(m_db));
        chk("model_fall", 32'(fall_p), 32'(m_fall));
        chk("model_rise", 32'(rise_p), 32'(m_rise));
        chk("model_any", 32'(any_act), 32'(m_any));
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] seen;
        int           t;
        logic         rs;

        // Reset with all inputs asserted: nothing may leak through
        for (int k = 0; k < 3; k++) begin
            tick(8'h00, 1'b0);
            chk("rst_db", 32'(db_n), 32'hFF);
            chk("rst_fall", 32'(fall_p), 32'h00);
            chk("rst_rise", 32'(rise_p), 32'h00);
            chk("rst_any", 32'(any_act), 32'h0);
        end
        for (int k = 0; k < 6; k++) tick(8'hFF, 1'b1);

        // Press on channel 7: edge k captures, db changes at k+5
        tick(8'h7F, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick(8'h7F, 1'b1);
            chk("press_hold_db", 32'(db_n), 32'hFF);
        end
        tick(8'h7F, 1'b1);
        chk("press_db", 32'(db_n), 32'h7F);
        chk("press_fall", 32'(fall_p), 32'h80);
        chk("press_rise", 32'(rise_p), 32'h00);
        chk("press_any", 32'(any_act), 32'h1);
        tick(8'h7F, 1'b1);
        chk("press_fall_clear", 32'(fall_p), 32'h00);
        for (int k = 0; k < 8; k++) tick(8'hFF, 1'b1);
        chk("press_release_db", 32'(db_n), 32'hFF);

        // Glitch shorter than DB at s2
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            tick(8'hF7, 1'b1);
            seen |= fall_p | rise_p;
        end
        for (int k = 0; k < 20; k++) begin
            tick(8'hFF, 1'b1);
            seen |= fall_p | rise_p;
        end
        chk("glitch_db", 32'(db_n), 32'hFF);
        chk("glitch_strobes", 32'(seen), 32'h00);

        // Bounce on channel 2, then settle low
        seen = '0;
        for (int p = 0; p < 4; p++) begin
            r = (p % 2 == 0) ? 8'hFB : 8'hFF;
            tick(r, 1'b1); seen |= fall_p | rise_p;
            tick(r, 1'b1); seen |= fall_p | rise_p;
        end
        chk("bounce_no_early", 32'(seen), 32'h00);
        tick(8'hFB, 1'b1);
        t = 0;
        while (fall_p == '0 && t < 20) begin
            tick(8'hFB, 1'b1);
            t++;
        end
        chk("bounce_latency", 32'(t), 32'd5);
        chk("bounce_fall", 32'(fall_p), 32'h04);
        for (int k = 0; k < 8; k++) tick(8'hFF, 1'b1);

        // Simultaneous press and release of several channels
        tick(8'h5A, 1'b1);
        t = 0;
        while (db_n == 8'hFF && t < 20) begin
            tick(8'h5A, 1'b1);
            t++;
        end
        chk("simul_latency", 32'(t), 32'd5);
        chk("simul_db", 32'(db_n), 32'h5A);
        chk("simul_fall", 32'(fall_p), 32'hA5);
        tick(8'hFF, 1'b1);
        t = 0;
        while (rise_p == '0 && t < 20) begin
            tick(8'hFF, 1'b1);
            t++;
        end
        chk("simul_rise", 32'(rise_p), 32'hA5);
        chk("simul_any_drop", 32'(any_act), 32'h0);
        tick(8'hFF, 1'b1);
        chk("simul_rise_clear", 32'(rise_p), 32'h00);

        // Reset mid-count discards progress
        tick(8'hFE, 1'b1);
        tick(8'hFE, 1'b1);
        tick(8'hFE, 1'b1);
        tick(8'hFE, 1'b1);
        tick(8'hFE, 1'b0);
        chk("midrst_db", 32'(db_n), 32'hFF);
        tick(8'hFE, 1'b0);
        chk("midrst_db2", 32'(db_n), 32'hFF);
        tick(8'hFE, 1'b1);
        t = 0;
        while (fall_p == '0 && t < 20) begin
            tick(8'hFE, 1'b1);
            t++;
        end
        chk("midrst_latency", 32'(t), 32'd5);
        chk("midrst_fall", 32'(fall_p), 32'h01);
        for (int k = 0; k < 8; k++) tick(8'hFF, 1'b1);

        // Random stretches: sparse toggles so both bounces and settled levels occur
        r = 8'hFF;
        for (int k = 0; k < 1500; k++) begin
            logic [N-1:0] flip;
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
            r  = r ^ flip;
            rs = ($urandom_range(0, 199) != 0);
            tick(r, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
